// File: rtl/rx_pkt_store_fwd_pkg.sv
// Shared definitions for the receive store-and-forward buffer:
// status bit positions, the stored word layout and the write FSM states.
package rx_pkt_store_fwd_pkg;

   localparam int STAT_SOP     = 7;
   localparam int STAT_EOP     = 6;
   localparam int STAT_MOD_LSB = 0;

   typedef struct packed {
      logic        eop;
      logic [2:0]  mod;
      logic [63:0] data;
   } mem_word_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DISCARD
   } wr_state_t;

endpackage

// File: rtl/rx_pkt_store_fwd_ram.sv
// Simple dual-port synchronous RAM with a registered read port that reads
// every cycle; the caller tracks which read results are meaningful.
module rx_pkt_store_fwd_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 68
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/rx_pkt_store_fwd.sv
// Store-and-forward packet buffer: whole packets are committed or rolled back
// on the write side, and only committed words are replayed downstream.
module rx_pkt_store_fwd
   import rx_pkt_store_fwd_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int DROP_ERR  = 1,
   parameter int AFULL_GAP = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [63:0] wr_data_i,
   input  logic [7:0]  wr_status_i,
   input  logic        wr_error_i,
   input  logic [15:0] wr_pkt_len_i,
   input  logic        wr_en_i,
   output logic        wr_full_o,
   output logic [63:0] pkt_data_o,
   output logic [2:0]  pkt_mod_o,
   output logic        pkt_sop_o,
   output logic        pkt_eop_o,
   output logic        pkt_val_o,
   input  logic        pkt_ready_i,
   output logic [31:0] good_pkt_cnt_o,
   output logic [31:0] drop_err_cnt_o,
   output logic [31:0] drop_ovf_cnt_o,
   output logic [31:0] good_byte_cnt_o
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] GAP   = (ADDR_W+1)'(AFULL_GAP);

   wr_state_t         state, state_n;
   logic [ADDR_W:0]   wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr;
   logic [ADDR_W:0]   base, base_used, used, readable;
   logic              in_sop, in_eop, accept, ram_we, good_inc, ovf_inc;
   logic [1:0]        err_add;
   logic [ADDR_W-1:0] ram_waddr;
   mem_word_t         ram_wdata, ram_rdata, head;
   mem_word_t         skid [2];
   logic              rd_pend, issue, pop, out_val, first_word;
   logic [1:0]        occ, fill_n;
   logic              unused_stat;

   assign in_sop      = wr_status_i[STAT_SOP];
   assign in_eop      = wr_status_i[STAT_EOP];
   assign unused_stat = ^wr_status_i[5:3];
   assign used        = wr_ptr - rd_ptr;
   assign readable    = wr_commit - rd_ptr;
   assign base_used   = base - rd_ptr;

   assign ram_wdata.eop  = in_eop;
   assign ram_wdata.mod  = in_eop ? wr_status_i[STAT_MOD_LSB +: 3] : 3'd0;
   assign ram_wdata.data = wr_data_i;

   // Write FSM: a new sop (including one that aborts an open packet) always
   // restarts from wr_commit, so a rollback never disturbs committed words.
   always_comb begin
      state_n     = state;
      wr_ptr_n    = wr_ptr;
      wr_commit_n = wr_commit;
      ram_we      = 1'b0;
      ram_waddr   = wr_ptr[ADDR_W-1:0];
      good_inc    = 1'b0;
      ovf_inc     = 1'b0;
      err_add     = 2'd0;
      accept      = 1'b0;
      base        = wr_ptr;
      if (wr_en_i) begin
         unique case (state)
            IDLE, DISCARD: begin
               if (in_sop) begin
                  accept = 1'b1;
                  base   = wr_commit;
               end else if (state == DISCARD && in_eop) begin
                  state_n = IDLE;
               end
            end
            WRITE: begin
               accept = 1'b1;
               if (in_sop) begin
                  err_add = 2'd1;
                  base    = wr_commit;
               end
            end
            default: state_n = IDLE;
         endcase
         if (accept) begin
            if (base_used == DEPTH) begin
               ovf_inc  = 1'b1;
               wr_ptr_n = wr_commit;
               state_n  = in_eop ? IDLE : DISCARD;
            end else begin
               ram_we    = 1'b1;
               ram_waddr = base[ADDR_W-1:0];
               if (in_eop) begin
                  state_n = IDLE;
                  if (wr_error_i && (DROP_ERR != 0)) begin
                     err_add  = err_add + 2'd1;
                     wr_ptr_n = wr_commit;
                  end else begin
                     good_inc    = 1'b1;
                     wr_commit_n = base + 1'b1;
                     wr_ptr_n    = base + 1'b1;
                  end
               end else begin
                  state_n  = WRITE;
                  wr_ptr_n = base + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         wr_commit       <= '0;
         wr_full_o       <= 1'b0;
         good_pkt_cnt_o  <= '0;
         drop_err_cnt_o  <= '0;
         drop_ovf_cnt_o  <= '0;
         good_byte_cnt_o <= '0;
      end else begin
         state          <= state_n;
         wr_ptr         <= wr_ptr_n;
         wr_commit      <= wr_commit_n;
         wr_full_o      <= (DEPTH - used) <= GAP;
         drop_err_cnt_o <= drop_err_cnt_o + {30'd0, err_add};
         if (good_inc) begin
            good_pkt_cnt_o  <= good_pkt_cnt_o + 32'd1;
            good_byte_cnt_o <= good_byte_cnt_o + {16'd0, wr_pkt_len_i};
         end
         if (ovf_inc) drop_ovf_cnt_o <= drop_ovf_cnt_o + 32'd1;
      end
   end

   rx_pkt_store_fwd_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (68)
   ) u_ram (
      .clk   (clk_i),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   // The RAM result is presented directly when the skid is empty; a read is
   // only issued if the word it returns is guaranteed a skid slot.
   assign out_val = (occ != 2'd0) || rd_pend;
   assign head    = (occ != 2'd0) ? skid[0] : ram_rdata;
   assign pop     = out_val && pkt_ready_i;
   assign fill_n  = occ + {1'b0, rd_pend} - {1'b0, pop};
   assign issue   = (readable != '0) && (fill_n <= 2'd1);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_ptr     <= '0;
         rd_pend    <= 1'b0;
         occ        <= 2'd0;
         first_word <= 1'b1;
      end else begin
         rd_pend <= issue;
         occ     <= fill_n;
         if (issue) rd_ptr <= rd_ptr + 1'b1;
         if (pop) first_word <= head.eop;
         if (occ == 2'd0) begin
            if (rd_pend && !pop) skid[0] <= ram_rdata;
         end else if (occ == 2'd1) begin
            if (pop) begin
               if (rd_pend) skid[0] <= ram_rdata;
            end else if (rd_pend) begin
               skid[1] <= ram_rdata;
            end
         end else if (pop) begin
            skid[0] <= skid[1];
            if (rd_pend) skid[1] <= ram_rdata;
         end
      end
   end

   always_comb begin
      pkt_val_o  = out_val;
      pkt_data_o = '0;
      pkt_mod_o  = '0;
      pkt_sop_o  = 1'b0;
      pkt_eop_o  = 1'b0;
      if (out_val) begin
         pkt_data_o = head.data;
         pkt_mod_o  = head.mod;
         pkt_sop_o  = first_word;
         pkt_eop_o  = head.eop;
      end
   end

endmodule

// File: tb/tb_rx_pkt_store_fwd.sv
// Scoreboard bench for rx_pkt_store_fwd: packets are judged good or dropped at
// packet level when sent, and a monitor compares every delivered word in order.
module tb_rx_pkt_store_fwd;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 2**ADDR_W;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [63:0] wr_data_i = '0;
   logic [7:0]  wr_status_i = '0;
   logic        wr_error_i = 1'b0;
   logic [15:0] wr_pkt_len_i = '0;
   logic        wr_en_i = 1'b0;
   logic        wr_full_o;
   logic [63:0] pkt_data_o;
   logic [2:0]  pkt_mod_o;
   logic        pkt_sop_o, pkt_eop_o, pkt_val_o;
   logic        pkt_ready_i = 1'b0;
   logic [31:0] good_pkt_cnt_o, drop_err_cnt_o, drop_ovf_cnt_o, good_byte_cnt_o;

   typedef struct {
      logic [63:0] data;
      logic [2:0]  mod;
      logic        sop;
      logic        eop;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_good = '0, m_err = '0, m_ovf = '0, m_bytes = '0;
   int          ready_mode = 0;
   logic        ready_hold = 1'b1;

   rx_pkt_store_fwd #(
      .ADDR_W    (ADDR_W),
      .DROP_ERR  (1),
      .AFULL_GAP (4)
   ) dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .wr_data_i       (wr_data_i),
      .wr_status_i     (wr_status_i),
      .wr_error_i      (wr_error_i),
      .wr_pkt_len_i    (wr_pkt_len_i),
      .wr_en_i         (wr_en_i),
      .wr_full_o       (wr_full_o),
      .pkt_data_o      (pkt_data_o),
      .pkt_mod_o       (pkt_mod_o),
      .pkt_sop_o       (pkt_sop_o),
      .pkt_eop_o       (pkt_eop_o),
      .pkt_val_o       (pkt_val_o),
      .pkt_ready_i     (pkt_ready_i),
      .good_pkt_cnt_o  (good_pkt_cnt_o),
      .drop_err_cnt_o  (drop_err_cnt_o),
      .drop_ovf_cnt_o  (drop_ovf_cnt_o),
      .good_byte_cnt_o (good_byte_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] d, input logic [7:0] st,
                                input logic err, input logic [15:0] len);
      wr_data_i    = d;
      wr_status_i  = st;
      wr_error_i   = err;
      wr_pkt_len_i = len;
      wr_en_i      = 1'b1;
      @(posedge clk_i); #1;
      wr_en_i    = 1'b0;
      wr_error_i = 1'b0;
   endtask

   // Packet fate follows the buffer rules: truncated or errored packets are
   // dropped, and a packet larger than the (empty) buffer overflows.
   task automatic send_packet(input int nw, input logic [2:0] mod, input logic err,
                              input bit truncate, input int gap_pct, input bit chk_full);
      logic [63:0] d;
      logic [7:0]  st;
      logic [15:0] len;
      logic        last, err_w;
      bit          good;
      len  = 16'((nw - 1) * 8 + ((mod == 3'd0) ? 8 : int'(mod)));
      good = !truncate && !err && (nw <= DEPTH);
      for (int i = 0; i < nw; i++) begin
         last  = (i == nw - 1) && !truncate;
         d     = {$urandom, $urandom};
         st    = '0;
         st[7] = (i == 0);
         st[6] = last;
         st[2:0] = last ? mod : 3'($urandom);
         err_w = last ? err : 1'($urandom);
         if (good) exp_q.push_back('{d, last ? mod : 3'd0, i == 0, last});
         applyStimulus(d, st, err_w, len);
         if (chk_full && i < DEPTH)
            checkOutput($sformatf("wr_full_w%0d", i), 64'(wr_full_o), 64'(i >= 12));
         if (i < nw - 1 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(posedge clk_i); #1;
         end
      end
      if (truncate || err) m_err++;
      else if (nw > DEPTH) m_ovf++;
      else begin
         m_good++;
         m_bytes += {16'd0, len};
      end
   endtask

   task automatic wait_room(input int nw);
      int n = 0;
      while (exp_q.size() + nw > DEPTH && n < 2000) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (n >= 2000) checkOutput("room_timeout", 64'(exp_q.size()), 64'(DEPTH - nw));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk_i); #1;
         n++;
      end
      repeat (4) @(posedge clk_i);
      #1;
      checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_counters(input string tag);
      checkOutput({tag, "_good"},  64'(good_pkt_cnt_o),  64'(m_good));
      checkOutput({tag, "_err"},   64'(drop_err_cnt_o),  64'(m_err));
      checkOutput({tag, "_ovf"},   64'(drop_ovf_cnt_o),  64'(m_ovf));
      checkOutput({tag, "_bytes"}, 64'(good_byte_cnt_o), 64'(m_bytes));
   endtask

   initial begin
      forever begin
         @(posedge clk_i); #1;
         case (ready_mode)
            0:       pkt_ready_i = ready_hold;
            1:       pkt_ready_i = ~pkt_ready_i;
            default: pkt_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares each accepted word with the scoreboard head and checks
   // that a stalled word is held unchanged until it is taken.
   initial begin
      exp_t        e;
      logic        held_v;
      logic [63:0] h_data;
      logic [4:0]  h_ctl;
      held_v = 1'b0;
      h_data = '0;
      h_ctl  = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            held_v = 1'b0;
            continue;
         end
         if (held_v) begin
            checkOutput("hold_val", 64'(pkt_val_o), 64'd1);
            checkOutput("hold_data", pkt_data_o, h_data);
            checkOutput("hold_ctl", 64'({pkt_mod_o, pkt_sop_o, pkt_eop_o}), 64'(h_ctl));
         end
         if (pkt_val_o) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_val", 64'(pkt_val_o), 64'd0);
            end else if (pkt_ready_i) begin
               e = exp_q.pop_front();
               checkOutput("out_data", pkt_data_o, e.data);
               checkOutput("out_mod", 64'(pkt_mod_o), 64'(e.mod));
               checkOutput("out_sop", 64'(pkt_sop_o), 64'(e.sop));
               checkOutput("out_eop", 64'(pkt_eop_o), 64'(e.eop));
            end
         end
         held_v = pkt_val_o && !pkt_ready_i;
         h_data = pkt_data_o;
         h_ctl  = {pkt_mod_o, pkt_sop_o, pkt_eop_o};
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      @(negedge clk_i);
      checkOutput("rst_val", 64'(pkt_val_o), 64'd0);
      checkOutput("rst_data", pkt_data_o, 64'd0);
      checkOutput("rst_full", 64'(wr_full_o), 64'd0);
      check_counters("rst");
      @(posedge clk_i); #1;

      $display("[TB] single 8-word packet, latency check");
      send_packet(8, 3'd4, 1'b0, 1'b0, 0, 1'b0);
      @(negedge clk_i);
      checkOutput("lat_c1_val", 64'(pkt_val_o), 64'd0);
      @(negedge clk_i);
      checkOutput("lat_c2_val", 64'(pkt_val_o), 64'd1);
      checkOutput("lat_c2_sop", 64'(pkt_sop_o), 64'd1);
      drain();
      check_counters("t1");

      $display("[TB] errored packet then good packet");
      send_packet(8, 3'd2, 1'b1, 1'b0, 0, 1'b0);
      send_packet(2, 3'd7, 1'b0, 1'b0, 0, 1'b0);
      drain();
      check_counters("t2");

      $display("[TB] overflow with ready low");
      ready_hold = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      send_packet(20, 3'd0, 1'b0, 1'b0, 0, 1'b1);
      send_packet(3, 3'd1, 1'b0, 1'b0, 0, 1'b0);
      repeat (5) @(posedge clk_i);
      #1;
      checkOutput("full_after_ovf", 64'(wr_full_o), 64'd0);
      check_counters("t3");
      ready_hold = 1'b1;
      drain();

      $display("[TB] back-to-back packets, ready toggling");
      ready_mode = 1;
      send_packet(5, 3'd3, 1'b0, 1'b0, 0, 1'b0);
      send_packet(1, 3'd5, 1'b0, 1'b0, 0, 1'b0);
      send_packet(9, 3'd6, 1'b0, 1'b0, 0, 1'b0);
      drain();
      check_counters("t4");
      ready_mode = 0;

      $display("[TB] missing eop aborts open packet");
      send_packet(4, 3'd0, 1'b0, 1'b1, 0, 1'b0);
      send_packet(6, 3'd3, 1'b0, 1'b0, 0, 1'b0);
      drain();
      check_counters("t5");

      $display("[TB] reset mid-packet");
      ready_hold = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      send_packet(3, 3'd2, 1'b0, 1'b0, 0, 1'b0);
      repeat (4) @(posedge clk_i);
      #1;
      send_packet(3, 3'd0, 1'b0, 1'b1, 0, 1'b0);
      rst_n_i = 1'b0;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      exp_q.delete();
      m_good  = '0;
      m_err   = '0;
      m_ovf   = '0;
      m_bytes = '0;
      @(negedge clk_i);
      checkOutput("post_rst_val", 64'(pkt_val_o), 64'd0);
      check_counters("t6_rst");
      ready_hold = 1'b1;
      @(posedge clk_i); #1;
      send_packet(4, 3'd6, 1'b0, 1'b0, 0, 1'b0);
      drain();
      check_counters("t6");

      $display("[TB] randomized traffic");
      ready_mode = 2;
      for (int p = 0; p < 40; p++) begin
         int nw;
         nw = $urandom_range(1, 10);
         wait_room(nw);
         send_packet(nw, 3'($urandom), 1'($urandom_range(0, 5) == 0), 1'b0, 30, 1'b0);
      end
      ready_mode = 0;
      ready_hold = 1'b1;
      drain();
      check_counters("t7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_pkt_store_fwd.md
Name: rx_pkt_store_fwd

Overview:
- Store-and-forward packet buffer fed directly by the dual PHY interface receive multiplexer (rx_engine_if fetcher-side signals: data/status/error/pkt_len/en, back-pressure wr_full).
- Buffers each packet completely, drops packets flagged with error or that overflow the buffer, and replays good packets as an eth_pkt_if-style stream (sop/eop/mod/val/ready) to the rx_engine.
- Single 156.25 MHz domain; whole-packet drop means the downstream never sees partial or errored frames.

Parameters:
- ADDR_W, 9, buffer depth = 2**ADDR_W 64-bit words (512 words = 4096 B).
- DROP_ERR, 1, 1 = discard packets whose eop word carries error; 0 = forward them.
- AFULL_GAP, 4, wr_full_o asserts when free words <= AFULL_GAP.

Ports:
- clk_i, input, 1, system clock (xgmii clock domain).
- rst_n_i, input, 1, reset, synchronous, active-low.
- wr_data_i, input, 64, fetcher data word.
- wr_status_i, input, 8, bit7 = sop, bit6 = eop, bits[2:0] = mod (0 = all 8 bytes valid).
- wr_error_i, input, 1, packet error, sampled on eop word.
- wr_pkt_len_i, input, 16, byte length, sampled on eop word (statistics only).
- wr_en_i, input, 1, word valid.
- wr_full_o, output, 1, registered almost-full to fetcher.
- pkt_data_o, output, 64, output data.
- pkt_mod_o, output, 3, valid bytes on eop word.
- pkt_sop_o, output, 1, first word.
- pkt_eop_o, output, 1, last word.
- pkt_val_o, output, 1, word valid.
- pkt_ready_i, input, 1, downstream accept.
- good_pkt_cnt_o, output, 32, committed packets, wraps.
- drop_err_cnt_o, output, 32, packets dropped for error or abort, wraps.
- drop_ovf_cnt_o, output, 32, packets dropped for overflow, wraps.
- good_byte_cnt_o, output, 32, sum of wr_pkt_len_i of committed packets, wraps.

Behaviour:
- Reset (rst_n_i low on a clock edge): all outputs 0, pointers 0, write FSM IDLE, in-flight packet discarded, all counters 0.
- Memory word = {eop, mod[2:0], data[63:0]} (68 bits). sop is regenerated on read as the first word after a read-side eop or after reset.
- Pointers: wr_ptr (tentative), wr_commit, rd_ptr, each ADDR_W+1 bits; wrap-around handled by the extra MSB. used = wr_ptr - rd_ptr; readable = wr_commit - rd_ptr.
- Write FSM states:
  - IDLE: en&sop -> write word; go WRITE, or stay IDLE if the same word has eop (commit as a single-word packet). en without sop -> ignored.
  - WRITE: en&!sop -> write word.
    - On eop: if error&DROP_ERR, set wr_ptr <= wr_commit and drop_err++; else set wr_commit <= wr_ptr+1, good++, good_byte += pkt_len. Return to IDLE.
    - en&sop (missing eop): roll back wr_ptr to wr_commit, drop_err++, then treat the word as a new sop.
  - DISCARD: ignore words until en&eop, then IDLE. A sop in DISCARD starts a new packet (as IDLE).
- Overflow: en while buffer full (used == 2**ADDR_W) in WRITE or IDLE/sop -> roll back wr_ptr to wr_commit, drop_ovf++, go DISCARD (or IDLE if that word has eop). Committed data is never overwritten.
- wr_full_o: registered, 1 cycle after (2**ADDR_W - used) <= AFULL_GAP.
- Read side:
  - Sync RAM with 1-cycle read latency, plus a 2-entry output skid register.
  - pkt_val_o only for committed words.
  - While pkt_val_o && !pkt_ready_i, all pkt_* outputs are held stable.
  - Transfer = pkt_val_o && pkt_ready_i.
  - Full throughput: 1 word/cycle with pkt_ready_i held high.
- Latency: the first word of a packet appears on pkt_val_o exactly 2 cycles after the eop write cycle, with the output empty and pkt_ready_i high.
- Simultaneous commit and read, and a rollback in the same cycle as a read: both legal; rd_ptr is never affected by a rollback.
- pkt_mod_o is 0 on non-eop words.

Decomposition:
- Package rx_pkt_store_fwd_pkg:
  - status bit positions (STAT_SOP = 7, STAT_EOP = 6, STAT_MOD_LSB = 0);
  - packed struct of the 68-bit memory word;
  - write FSM enum (IDLE, WRITE, DISCARD).
- Sub-module rx_pkt_store_fwd_ram: simple dual-port synchronous RAM, parameters ADDR_W and DATA_W = 68, registered read, no output enable.

Test Plan:
- 8-word packet, last mod = 4, no error, ready = 1 -> 8 output words, sop on word 0, eop+mod = 4 on word 7, first val 2 cycles after eop write; good_pkt_cnt = 1, good_byte_cnt += wr_pkt_len_i (60).
- 8-word packet with error = 1 on eop, DROP_ERR = 1 -> no pkt_val_o; drop_err_cnt = 1; buffer used returns to 0; a following 2-word good packet is delivered intact.
- ADDR_W = 4, ready = 0, 20-word packet -> drop_ovf_cnt = 1, no output; then a 3-word packet -> delivered once ready = 1; wr_full_o high once used >= 12.
- Three back-to-back packets (5 words, 1 word sop+eop with mod = 5, 9 words), ready toggling 1010… -> word order and data identical, outputs stable while ready = 0, two sop/eop pairs plus one combined sop+eop word.
- sop arrives on word 4 of an open packet -> first packet dropped (drop_err_cnt = 1), second packet delivered complete.
- rst_n_i low for 1 cycle mid-packet on both write and read sides -> next cycle pkt_val_o = 0, all counters 0; the next full packet passes normally.
